// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb controller and the puzzle modules.
//   bomb_state_t : 3-bit global state broadcast on current_state
//   LFSR_SEED    : reset/recovery value of the rnd bus
//   LFSR_TAPS    : Galois mask for x^32+x^22+x^2+x+1 (right-shift form)
//   SEC_W        : width of the seconds countdown
package bomb_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'b000,
    ACTIVATING        = 3'b001,
    ACTIVATED         = 3'b010,
    DETONATING        = 3'b011,
    MISSION_FAILED    = 3'b100,
    MISSION_SUCCESSED = 3'b101
  } bomb_state_t;

  localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int unsigned SEC_W     = 10;

  // One Galois step; an all-zero register is locked up, so reseed instead.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    if (cur == '0) return LFSR_SEED;
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/bomb_countdown_timer.sv
// Countdown timer: 1 s prescaler, tick pulse and seconds register.
//   clk, rst    : clock, asynchronous active-low reset
//   load        : reload seconds with START_SECONDS, clear prescaler
//   run         : prescaler/decrement enable
//   tick        : registered one-cycle pulse on each prescaler wrap
//   seconds     : registered countdown value
//   zero_next   : combinational, seconds reaches 0 on this clock edge
module bomb_countdown_timer
  import bomb_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned START_SECONDS = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  output logic             tick,
  output logic [SEC_W-1:0] seconds,
  output logic             zero_next
);

  localparam int unsigned PW = $clog2(CLK_HZ + 1);
  localparam logic [PW-1:0] WRAP_VAL = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap      = run && (presc == WRAP_VAL);
  assign zero_next = wrap && (seconds == SEC_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      tick    <= 1'b0;
      seconds <= SEC_W'(START_SECONDS);
    end else if (load) begin
      presc   <= '0;
      tick    <= 1'b0;
      seconds <= SEC_W'(START_SECONDS);
    end else begin
      tick <= wrap;
      if (run) presc <= wrap ? '0 : presc + 1'b1;
      if (wrap && (seconds != '0)) seconds <= seconds - 1'b1;
    end
  end

endmodule

// File: rtl/bomb_center_controller.sv
// Central game sequencer: global state, rnd seed bus, strikes, countdown.
//   clk, rst          : clock, asynchronous active-low reset
//   start_btn         : debounced start/restart level
//   module_activated  : per-module activated level
//   module_failed     : per-module one-clock strike pulse
//   module_solved     : per-module solved level
//   current_state     : global state broadcast
//   rnd               : free-running LFSR
//   strikes           : strike count
//   seconds_left      : countdown value
//   tick_1hz          : one pulse per elapsed second while ACTIVATED
//   detonate          : high while DETONATING
module bomb_center_controller
  import bomb_pkg::*;
#(
  parameter int unsigned NUM_MODULES     = 4,
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned START_SECONDS   = 300,
  parameter int unsigned MAX_STRIKES     = 3,
  parameter int unsigned ACT_TIMEOUT_CYC = 1_000_000,
  parameter int unsigned DETONATE_CYC    = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_btn,
  input  logic [NUM_MODULES-1:0] module_activated,
  input  logic [NUM_MODULES-1:0] module_failed,
  input  logic [NUM_MODULES-1:0] module_solved,
  output logic [2:0]             current_state,
  output logic [31:0]            rnd,
  output logic [1:0]             strikes,
  output logic [SEC_W-1:0]       seconds_left,
  output logic                   tick_1hz,
  output logic                   detonate
);

  localparam int unsigned ACT_W = $clog2(ACT_TIMEOUT_CYC + 1);
  localparam int unsigned DET_W = $clog2(DETONATE_CYC + 1);
  localparam logic [2:0]  MAX_S = 3'(MAX_STRIKES);

  bomb_state_t      state;
  logic             start_q;
  logic             start_edge;
  logic [ACT_W-1:0] act_cnt;
  logic [DET_W-1:0] det_cnt;
  logic             timer_load;
  logic             timer_run;
  logic             zero_next;
  logic [2:0]       strk_sum;
  logic [2:0]       nstrk;

  assign start_edge    = start_btn & ~start_q;
  assign timer_load    = (state == IDLE) && start_edge;
  assign timer_run     = (state == ACTIVATED);
  assign current_state = state;

  // Simultaneous failures from several modules count as a single strike.
  always_comb begin
    strk_sum = {1'b0, strikes} + {2'b00, |module_failed};
    nstrk    = (strk_sum >= MAX_S) ? MAX_S : strk_sum;
  end

  bomb_countdown_timer #(
    .CLK_HZ        (CLK_HZ),
    .START_SECONDS (START_SECONDS)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .run       (timer_run),
    .tick      (tick_1hz),
    .seconds   (seconds_left),
    .zero_next (zero_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rnd <= LFSR_SEED;
    else      rnd <= lfsr_next(rnd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      strikes  <= '0;
      act_cnt  <= '0;
      det_cnt  <= '0;
      detonate <= 1'b0;
    end else begin
      start_q <= start_btn;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state   <= ACTIVATING;
            strikes <= '0;
            act_cnt <= '0;
          end
        end
        ACTIVATING: begin
          act_cnt <= act_cnt + 1'b1;
          if (&module_activated)
            state <= ACTIVATED;
          else if (act_cnt == ACT_W'(ACT_TIMEOUT_CYC - 1))
            state <= MISSION_FAILED;
        end
        ACTIVATED: begin
          strikes <= nstrk[1:0];
          if (nstrk == MAX_S || (!(&module_solved) && zero_next)) begin
            state    <= DETONATING;
            det_cnt  <= '0;
            detonate <= 1'b1;
          end else if (&module_solved) begin
            state <= MISSION_SUCCESSED;
          end
        end
        DETONATING: begin
          det_cnt <= det_cnt + 1'b1;
          if (det_cnt == DET_W'(DETONATE_CYC - 1)) begin
            state    <= MISSION_FAILED;
            detonate <= 1'b0;
          end
        end
        MISSION_FAILED, MISSION_SUCCESSED: begin
          if (start_edge) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          detonate <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_center_controller.sv
// Self-checking bench for bomb_center_controller (small parameter set).
module tb_bomb_center_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic [1:0]  act = 2'b00;
  logic [1:0]  failed = 2'b00;
  logic [1:0]  solved = 2'b00;
  logic [2:0]  cur_state;
  logic [31:0] rnd;
  logic [1:0]  strikes;
  logic [9:0]  seconds_left;
  logic        tick_1hz;
  logic        detonate;

  always #5 clk = ~clk;

  bomb_center_controller #(
    .NUM_MODULES     (2),
    .CLK_HZ          (10),
    .START_SECONDS   (5),
    .MAX_STRIKES     (3),
    .ACT_TIMEOUT_CYC (20),
    .DETONATE_CYC    (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_btn        (start_btn),
    .module_activated (act),
    .module_failed    (failed),
    .module_solved    (solved),
    .current_state    (cur_state),
    .rnd              (rnd),
    .strikes          (strikes),
    .seconds_left     (seconds_left),
    .tick_1hz         (tick_1hz),
    .detonate         (detonate)
  );

  typedef enum int {F_STATE, F_STRK, F_SEC, F_DET, F_TICK, F_RND} field_t;
  typedef struct {
    string       name;
    field_t      f;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    bit          new_game;
    logic [1:0]  f;
    logic [1:0]  s;
    logic [2:0]  st;
    logic [1:0]  stk;
    string       name;
  } vec_t;

  localparam int NV = 12;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  chk_t sb[$];
  vec_t vt[NV];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] actual(input field_t f);
    case (f)
      F_STATE: return {29'b0, cur_state};
      F_STRK:  return {30'b0, strikes};
      F_SEC:   return {22'b0, seconds_left};
      F_DET:   return {31'b0, detonate};
      F_TICK:  return {31'b0, tick_1hz};
      default: return rnd;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] m);
    return m[0] ? ((m >> 1) ^ 32'h8020_0003) : (m >> 1);
  endfunction

  task automatic push(input string n, input field_t f, input logic [31:0] e);
    chk_t c;
    c.name = n; c.f = f; c.exp = e;
    sb.push_back(c);
  endtask

  task automatic drain();
    chk_t c;
    logic [31:0] a;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      a = actual(c.f);
      n_cmp++;
      if (a !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", c.name, a, c.exp, $time);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  // Wait (bounded) for a resting state, then bring the game back to IDLE.
  task automatic to_idle();
    int k;
    k = 0;
    failed = 2'b00; solved = 2'b00; start_btn = 1'b0;
    while (!(cur_state inside {3'b000, 3'b100, 3'b101}) && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (!(cur_state inside {3'b000, 3'b100, 3'b101})) begin
      n_bad++;
      $display("FAIL settle_timeout: got state %0d expected terminal or idle", cur_state);
    end
    if (cur_state != 3'b000) begin
      start_btn = 1'b1;
      push("restart_idle", F_STATE, 32'd0);
      step();
      start_btn = 1'b0;
      step();
    end
  endtask

  task automatic arm(input logic [1:0] a);
    act = a;
    start_btn = 1'b1;
    push("arm_state", F_STATE, 32'd1);
    push("arm_seconds", F_SEC, 32'd5);
    push("arm_strikes", F_STRK, 32'd0);
    step();
    start_btn = 1'b0;
  endtask

  task automatic go_activated();
    to_idle();
    arm(2'b11);
    push("activated_state", F_STATE, 32'd2);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m;

    vt = '{
      '{1'b1, 2'b11, 2'b00, 3'b010, 2'd1, "strike_multi_one"},
      '{1'b0, 2'b00, 2'b00, 3'b010, 2'd1, "strike_hold1"},
      '{1'b0, 2'b01, 2'b00, 3'b010, 2'd2, "strike_two"},
      '{1'b0, 2'b00, 2'b00, 3'b010, 2'd2, "strike_hold2"},
      '{1'b0, 2'b01, 2'b00, 3'b011, 2'd3, "strike_three_det"},
      '{1'b0, 2'b11, 2'b00, 3'b011, 2'd3, "det_ignores_fail"},
      '{1'b1, 2'b01, 2'b00, 3'b010, 2'd1, "g2_strike1"},
      '{1'b0, 2'b01, 2'b00, 3'b010, 2'd2, "g2_strike2"},
      '{1'b0, 2'b01, 2'b11, 3'b011, 2'd3, "det_beats_solve"},
      '{1'b1, 2'b01, 2'b00, 3'b010, 2'd1, "g3_strike1"},
      '{1'b0, 2'b01, 2'b11, 3'b101, 2'd2, "solve_with_strike"},
      '{1'b0, 2'b01, 2'b00, 3'b101, 2'd2, "success_ignores_fail"}
    };

    // Reset values
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    push("rst_state", F_STATE, 32'd0);
    push("rst_rnd", F_RND, SEED);
    push("rst_strikes", F_STRK, 32'd0);
    push("rst_seconds", F_SEC, 32'd5);
    push("rst_tick", F_TICK, 32'd0);
    push("rst_det", F_DET, 32'd0);
    drain();
    rst = 1'b1;
    step();

    // Start with late activation
    arm(2'b00);
    push("activating_1", F_STATE, 32'd1); step();
    push("activating_2", F_STATE, 32'd1); step();
    act = 2'b11;
    push("t1_activated", F_STATE, 32'd2);
    push("t1_seconds", F_SEC, 32'd5);
    push("t1_strikes", F_STRK, 32'd0);
    step();

    // Countdown to zero, detonation, then mission failed
    for (int k = 1; k <= 54; k++) begin
      if (k <= 50) begin
        push("cd_tick", F_TICK, (k % 10 == 0) ? 32'd1 : 32'd0);
        push("cd_seconds", F_SEC, 32'(5 - k / 10));
      end else begin
        push("det_tick", F_TICK, 32'd0);
        push("det_seconds_hold", F_SEC, 32'd0);
      end
      push("cd_state", F_STATE, (k < 50) ? 32'd2 : (k < 54) ? 32'd3 : 32'd4);
      push("cd_detonate", F_DET, (k >= 50 && k < 54) ? 32'd1 : 32'd0);
      step();
    end

    // Restart needs a fresh edge after returning to IDLE
    start_btn = 1'b1;
    push("fail_to_idle", F_STATE, 32'd0); step();
    push("held_start_stays_idle", F_STATE, 32'd0); step();
    start_btn = 1'b0;
    step();

    // Strike counting and priority vectors
    for (int i = 0; i < NV; i++) begin
      if (vt[i].new_game) go_activated();
      failed = vt[i].f;
      solved = vt[i].s;
      push({vt[i].name, "_state"}, F_STATE, {29'b0, vt[i].st});
      push({vt[i].name, "_strikes"}, F_STRK, {30'b0, vt[i].stk});
      step();
      failed = 2'b00;
      solved = 2'b00;
    end

    // Activation timeout
    to_idle();
    arm(2'b01);
    for (int k = 1; k <= 20; k++) begin
      push("act_timeout_state", F_STATE, (k < 20) ? 32'd1 : 32'd4);
      push("act_timeout_det", F_DET, 32'd0);
      step();
    end
    push("timeout_held_failed", F_STATE, 32'd4);
    push("timeout_no_det", F_DET, 32'd0);
    step();

    // Reset mid-countdown
    go_activated();
    for (int k = 1; k <= 20; k++) step();
    push("pre_reset_seconds", F_SEC, 32'd3);
    drain();
    rst = 1'b0;
    #1;
    push("mid_rst_state", F_STATE, 32'd0);
    push("mid_rst_seconds", F_SEC, 32'd5);
    push("mid_rst_strikes", F_STRK, 32'd0);
    push("mid_rst_rnd", F_RND, SEED);
    push("mid_rst_det", F_DET, 32'd0);
    drain();
    rst = 1'b1;
    m = SEED;
    for (int k = 0; k < 20; k++) begin
      m = model_next(m);
      push("lfsr_seq", F_RND, m);
      step();
      n_cmp++;
      if (rnd == 32'd0) begin
        n_bad++;
        $display("FAIL lfsr_nonzero: got %0h expected nonzero", rnd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
